// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: throttle width and the controller state
// encoding, also used by the PWM generator.
package motor_ctrl_pkg;

  localparam int THROTTLE_W = 15;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAULT    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_divider
  import motor_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] TICK_DIV = 16'd2700
) (
  input  logic clk_i,
  input  logic nreset_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == TICK_DIV - 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/throttle_ramp_controller.sv
// Throttle ramp controller: arming hold, slew-limited throttle ramp and a
// command watchdog, feeding the PWM generator.
module throttle_ramp_controller
  import motor_ctrl_pkg::*;
#(
  parameter logic [THROTTLE_W-1:0] STEP          = 15'd64,
  parameter logic [CNT_W-1:0]      TICK_DIV      = 16'd2700,
  parameter logic [CNT_W-1:0]      ARM_TICKS     = 16'd5000,
  parameter logic [CNT_W-1:0]      TIMEOUT_TICKS = 16'd2000
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [THROTTLE_W-1:0] cmd_throttle_i,
  input  logic                  cmd_digital_i,
  input  logic                  arm_i,
  output logic [THROTTLE_W-1:0] throttle_o,
  output logic                  is_digital_o,
  output logic                  armed_o,
  output logic                  fault_o
);

  ctrl_state_e           state_q, state_d;
  logic [THROTTLE_W-1:0] target_q, target_d;
  logic [THROTTLE_W-1:0] throttle_q, throttle_d;
  logic                  digital_q, digital_d;
  logic                  ready_q;
  logic [CNT_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;

  logic                  tick;
  logic                  accept;
  logic [CNT_W-1:0]      up_gap;
  logic [CNT_W-1:0]      dn_gap;
  logic [THROTTLE_W-1:0] ramp_val;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .tick_o   (tick)
  );

  assign accept       = cmd_valid_i & ready_q;
  assign cmd_ready_o  = ready_q;
  assign throttle_o   = throttle_q;
  assign is_digital_o = digital_q;
  assign armed_o      = (state_q == ST_ARMED);
  assign fault_o      = (state_q == ST_FAULT);

  // Gaps are taken 16 bits wide so the step comparison never wraps; the
  // step is only added or subtracted when it cannot pass the target.
  always_comb begin
    up_gap   = {1'b0, target_q} - {1'b0, throttle_q};
    dn_gap   = {1'b0, throttle_q} - {1'b0, target_q};
    ramp_val = target_q;
    if (target_q > throttle_q) begin
      if (up_gap > {1'b0, STEP}) begin
        ramp_val = throttle_q + STEP;
      end
    end else if (throttle_q > target_q) begin
      if (dn_gap > {1'b0, STEP}) begin
        ramp_val = throttle_q - STEP;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = accept ? cmd_throttle_i : target_q;
    throttle_d = '0;
    digital_d  = digital_q;
    arm_cnt_d  = arm_cnt_q;
    wd_cnt_d   = '0;

    case (state_q)
      ST_DISARMED: begin
        arm_cnt_d = '0;
        if (accept) begin
          digital_d = cmd_digital_i;
        end
        if (arm_i && (target_q == '0)) begin
          state_d = ST_ARMING;
        end
      end

      ST_ARMING: begin
        if (!arm_i || (accept && (cmd_throttle_i != '0))) begin
          state_d = ST_DISARMED;
        end else if (tick) begin
          if ((arm_cnt_q + 16'd1) >= ARM_TICKS) begin
            state_d   = ST_ARMED;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 16'd1;
          end
        end
      end

      // Disarm beats timeout; an accepted command beats a tick for the watchdog.
      ST_ARMED: begin
        if (!arm_i) begin
          state_d = ST_DISARMED;
        end else begin
          throttle_d = tick ? ramp_val : throttle_q;
          if (accept) begin
            wd_cnt_d = '0;
          end else if (tick) begin
            if ((wd_cnt_q + 16'd1) >= TIMEOUT_TICKS) begin
              state_d    = ST_FAULT;
              throttle_d = '0;
            end else begin
              wd_cnt_d = wd_cnt_q + 16'd1;
            end
          end else begin
            wd_cnt_d = wd_cnt_q;
          end
        end
      end

      ST_FAULT: begin
        if (!arm_i) begin
          state_d  = ST_DISARMED;
          target_d = '0;
        end
      end

      default: begin
        state_d = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_DISARMED;
      target_q   <= '0;
      throttle_q <= '0;
      digital_q  <= 1'b0;
      ready_q    <= 1'b0;
      arm_cnt_q  <= '0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      throttle_q <= throttle_d;
      digital_q  <= digital_d;
      ready_q    <= (state_d != ST_FAULT);
      arm_cnt_q  <= arm_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_throttle_ramp_controller.sv
// Self-checking bench for throttle_ramp_controller: a behavioural model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_throttle_ramp_controller;

  localparam int STEP          = 100;
  localparam int TICK_DIV      = 4;
  localparam int ARM_TICKS     = 3;
  localparam int TIMEOUT_TICKS = 10;

  localparam int MD_OFF    = 0;
  localparam int MD_ARMING = 1;
  localparam int MD_ARMED  = 2;
  localparam int MD_FAULT  = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [14:0] cmdThrottle = '0;
  logic        cmdDigital = 1'b0;
  logic        arm = 1'b0;
  logic [14:0] throttleOut;
  logic        isDigital;
  logic        armedOut;
  logic        faultOut;

  int assertCount = 0;
  int failCount   = 0;

  int mMode    = MD_OFF;
  int mTarget  = 0;
  int mThr     = 0;
  int mDigital = 0;
  int mReady   = 0;
  int mPhase   = 0;
  int mArmCnt  = 0;
  int mIdle    = 0;
  int mOldTgt  = 0;
  bit mTick;
  bit mAcc;

  throttle_ramp_controller #(
    .STEP          (15'd100),
    .TICK_DIV      (16'd4),
    .ARM_TICKS     (16'd3),
    .TIMEOUT_TICKS (16'd10)
  ) dut (
    .clk_i          (clk),
    .nreset_i       (nreset),
    .cmd_valid_i    (cmdValid),
    .cmd_ready_o    (cmdReady),
    .cmd_throttle_i (cmdThrottle),
    .cmd_digital_i  (cmdDigital),
    .arm_i          (arm),
    .throttle_o     (throttleOut),
    .is_digital_o   (isDigital),
    .armed_o        (armedOut),
    .fault_o        (faultOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input int thr, input bit digital, input bit armLvl);
    cmdValid    = valid;
    cmdThrottle = thr[14:0];
    cmdDigital  = digital;
    arm         = armLvl;
    @(negedge clk);
  endtask

  function automatic int rampToward(input int cur, input int tgt);
    if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
    if (tgt < cur) return (cur - STEP > tgt) ? cur - STEP : tgt;
    return cur;
  endfunction

  // Reference behaviour: one decision per clock from the rules of each mode.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mMode = MD_OFF; mTarget = 0; mThr = 0; mDigital = 0;
      mReady = 0; mPhase = 0; mArmCnt = 0; mIdle = 0;
    end else begin
      mTick   = (mPhase == TICK_DIV - 1);
      mAcc    = cmdValid && (mReady != 0);
      mOldTgt = mTarget;
      if (mAcc) mTarget = int'(cmdThrottle);
      case (mMode)
        MD_OFF: begin
          if (mAcc) mDigital = int'(cmdDigital);
          if (arm && mOldTgt == 0) begin
            mMode = MD_ARMING;
            mArmCnt = 0;
          end
        end
        MD_ARMING: begin
          if (!arm || (mAcc && cmdThrottle != 0)) mMode = MD_OFF;
          else if (mTick) begin
            mArmCnt++;
            if (mArmCnt >= ARM_TICKS) begin
              mMode = MD_ARMED;
              mIdle = 0;
            end
          end
        end
        MD_ARMED: begin
          if (!arm) begin
            mMode = MD_OFF;
            mThr = 0;
          end else begin
            if (mTick) mThr = rampToward(mThr, mOldTgt);
            if (mAcc) mIdle = 0;
            else if (mTick) begin
              mIdle++;
              if (mIdle >= TIMEOUT_TICKS) begin
                mMode = MD_FAULT;
                mThr = 0;
              end
            end
          end
        end
        default: begin
          if (!arm) begin
            mMode = MD_OFF;
            mTarget = 0;
          end
        end
      endcase
      mReady = (mMode != MD_FAULT) ? 1 : 0;
      mPhase = mTick ? 0 : mPhase + 1;
    end
  end

  // Every cycle the outputs are compared against the reference.
  always @(negedge clk) begin
    checkOutput("modelThrottle", int'(throttleOut), mThr);
    checkOutput("modelDigital", int'(isDigital), mDigital);
    checkOutput("modelArmed", int'(armedOut), (mMode == MD_ARMED) ? 1 : 0);
    checkOutput("modelFault", int'(faultOut), (mMode == MD_FAULT) ? 1 : 0);
    checkOutput("modelReady", int'(cmdReady), mReady);
  end

  task automatic waitArmed(input string name, output int cycles);
    cycles = 0;
    while (!armedOut && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, int'(armedOut), 1);
  endtask

  task automatic expectNextThrottle(input string name, input int expected);
    int prev = int'(throttleOut);
    bit changed = 0;
    for (int i = 0; i < 12 && !changed; i++) begin
      @(negedge clk);
      if (int'(throttleOut) != prev) changed = 1;
    end
    checkOutput(name, int'(throttleOut), expected);
  endtask

  initial begin
    int cycles;
    int sawArmed;
    int r;
    int thr;
    bit armLvl;

    repeat (3) @(negedge clk);
    checkOutput("resetReady", int'(cmdReady), 0);
    checkOutput("resetThrottle", int'(throttleOut), 0);
    nreset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("readyAfterReset", int'(cmdReady), 1);

    // Arm with no command: armed after three ticks, throttle stays zero.
    cmdValid = 0;
    arm = 1;
    waitArmed("armNoCmd", cycles);
    checkOutput("armDelayMin", (cycles >= 8) ? 1 : 0, 1);
    checkOutput("armedThrottleZero", int'(throttleOut), 0);

    applyStimulus(1, 350, 0, 1);
    cmdValid = 0;
    expectNextThrottle("rampUp1", 100);
    expectNextThrottle("rampUp2", 200);
    expectNextThrottle("rampUp3", 300);
    expectNextThrottle("rampUp4", 350);
    applyStimulus(1, 120, 0, 1);
    cmdValid = 0;
    expectNextThrottle("rampDn1", 250);
    expectNextThrottle("rampDn2", 150);
    expectNextThrottle("rampDn3", 120);

    // Watchdog timeout, then clear the fault by dropping arm.
    cycles = 0;
    while (!faultOut && cycles < 80) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("timeoutFault", int'(faultOut), 1);
    checkOutput("faultThrottle", int'(throttleOut), 0);
    checkOutput("faultReady", int'(cmdReady), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("faultCleared", int'(faultOut), 0);
    checkOutput("disarmedReady", int'(cmdReady), 1);

    applyStimulus(1, 0, 1, 0);
    cmdValid = 0;
    checkOutput("digitalLoad", int'(isDigital), 1);
    arm = 1;
    waitArmed("armForMode", cycles);
    applyStimulus(1, 0, 0, 1);
    cmdValid = 0;
    checkOutput("digitalHeld", int'(isDigital), 1);

    // A nonzero command while arming aborts back to disarmed.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 500, 0, 1);
    cmdValid = 0;
    sawArmed = 0;
    repeat (20) begin
      @(negedge clk);
      if (armedOut) sawArmed = 1;
    end
    checkOutput("armingAbort", sawArmed, 0);
    checkOutput("abortThrottle", int'(throttleOut), 0);

    applyStimulus(1, 0, 0, 1);
    cmdValid = 0;
    waitArmed("rearmForTop", cycles);
    cmdValid = 1;
    cmdThrottle = 15'd32700;
    cycles = 0;
    while (int'(throttleOut) != 32700 && cycles < 1500) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reach32700", int'(throttleOut), 32700);
    cmdThrottle = 15'd32767;
    expectNextThrottle("topClamp", 32767);
    repeat (8) @(negedge clk);
    checkOutput("topNoWrap", int'(throttleOut), 32767);

    // Asynchronous reset pulse in the middle of a ramp.
    applyStimulus(1, 20000, 0, 1);
    cmdValid = 0;
    repeat (6) @(negedge clk);
    checkOutput("midRamp", (throttleOut != 0 && throttleOut != 15'd20000) ? 1 : 0, 1);
    @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    checkOutput("asyncThrottle", int'(throttleOut), 0);
    checkOutput("asyncArmed", int'(armedOut), 0);
    checkOutput("asyncReady", int'(cmdReady), 0);
    #2 nreset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rearmRequired", int'(armedOut), 0);
    waitArmed("rearmAfterReset", cycles);

    // Random traffic: a busy phase and a sparse phase that lets faults occur.
    armLvl = 1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 99) < 3) armLvl = ~armLvl;
        r = int'($urandom_range(0, 9));
        if (r < 3) thr = 0;
        else if (r < 5) thr = int'($urandom_range(32000, 32767));
        else thr = int'($urandom_range(0, 32767));
        applyStimulus((phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0),
                      thr, $urandom_range(0, 1) == 1, armLvl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
